// File: rtl/ram_arbiter_pkg.sv
// Shared types and limits for the two-master RAM arbiter (instruction fetch vs. data access).
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    ACK     = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  localparam int RD_LATENCY_MAX = 4;
  localparam int LAT_CNT_W      = $clog2(RD_LATENCY_MAX);

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the fetch/data masters, the arbiter and the shared BRAM.
interface ram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  i_req_i;
  logic [ADDR_W-1:0]     i_addr_i;
  logic                  i_flush_i;
  logic                  i_ack_o;
  logic [DATA_W-1:0]     i_rdata_o;
  logic                  d_req_i;
  logic                  d_we_i;
  logic [DATA_W/8-1:0]   d_be_i;
  logic [ADDR_W-1:0]     d_addr_i;
  logic [DATA_W-1:0]     d_wdata_i;
  logic                  d_ack_o;
  logic [DATA_W-1:0]     d_rdata_o;
  logic [ADDR_W-1:0]     ram_addr_o;
  logic                  ram_re_o;
  logic [DATA_W/8-1:0]   ram_we_o;
  logic [DATA_W-1:0]     ram_wdata_o;
  logic [DATA_W-1:0]     ram_rdata_i;
  logic                  busy_o;

  modport slave (
    input  i_req_i, i_addr_i, i_flush_i, d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
           ram_rdata_i,
    output i_ack_o, i_rdata_o, d_ack_o, d_rdata_o, ram_addr_o, ram_re_o, ram_we_o,
           ram_wdata_o, busy_o
  );

  modport master (
    output i_req_i, i_addr_i, i_flush_i, d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
           ram_rdata_i,
    input  i_ack_o, i_rdata_o, d_ack_o, d_rdata_o, ram_addr_o, ram_re_o, ram_we_o,
           ram_wdata_o, busy_o
  );

endinterface

// File: rtl/ram_arbiter_priority_sel.sv
// Grant decision: data wins over fetch unless the starvation guard has tripped; flushed fetch is never granted.
module arb_priority_sel (
  input  logic en,
  input  logic i_req,
  input  logic d_req,
  input  logic flush,
  input  logic streak_hit,
  output logic gnt_i,
  output logic gnt_d
);

  logic i_ok;

  assign i_ok = i_req & ~flush;

  // pick at most one winner
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (en && streak_hit && i_ok) begin
      gnt_i = 1'b1;
    end else if (en && d_req) begin
      gnt_d = 1'b1;
    end else if (en && i_ok) begin
      gnt_i = 1'b1;
    end else begin
      gnt_i = 1'b0;
      gnt_d = 1'b0;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Serialises fetch and data accesses onto one BRAM, one transaction in flight at a time.
// Optional fetch starvation guard: define RAM_ARB_STARVE_GUARD_EN.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int RD_LATENCY      = 1,
  parameter int MAX_DATA_STREAK = 4
) (
  input logic         clk_i,
  input logic         n_rst,
  ram_arbiter_if.slave bus
);

  arb_state_t           state, state_nx;
  arb_owner_t           owner, owner_nx;
  logic [LAT_CNT_W-1:0] cnt, cnt_nx;
  logic                 flushed, flushed_nx;
  logic                 wr, wr_nx;
  logic                 i_ack, d_ack;
  logic [DATA_W-1:0]    i_rdata, d_rdata;
  logic                 grant_en, gnt_i, gnt_d, streak_hit;
  logic                 i_done, d_done;

  // The owner's req is still high in its ack cycle, so no arbitration then
  assign grant_en = n_rst && (state == IDLE) && !i_ack && !d_ack;

  arb_priority_sel u_sel (
    .en         (grant_en),
    .i_req      (bus.i_req_i),
    .d_req      (bus.d_req_i),
    .flush      (bus.i_flush_i),
    .streak_hit (streak_hit),
    .gnt_i      (gnt_i),
    .gnt_d      (gnt_d)
  );

`ifdef RAM_ARB_STARVE_GUARD_EN
  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  logic [STREAK_W-1:0] streak;

  assign streak_hit = (streak == STREAK_W'(MAX_DATA_STREAK));

  // count data grants made while fetch is waiting
  always_ff @(posedge clk_i) begin
    if (!n_rst || !bus.i_req_i || gnt_i) begin
      streak <= {STREAK_W{1'b0}};
    end else if (gnt_d && !streak_hit) begin
      streak <= streak + STREAK_W'(1);
    end else begin
      streak <= streak;
    end
  end
`else
  assign streak_hit = 1'b0;
`endif

  assign i_done = (state == ACK) && (owner == OWN_I) && !flushed && !bus.i_flush_i;
  assign d_done = (state == ACK) && (owner == OWN_D) && !wr;

  // next state and the RAM strobes, which exist only in the grant cycle
  always_comb begin
    state_nx        = state;
    owner_nx        = owner;
    cnt_nx          = cnt;
    flushed_nx      = flushed;
    wr_nx           = wr;
    bus.ram_addr_o  = {ADDR_W{1'b0}};
    bus.ram_re_o    = 1'b0;
    bus.ram_we_o    = {(DATA_W/8){1'b0}};
    bus.ram_wdata_o = {DATA_W{1'b0}};
    case (state)
      IDLE: begin
        if (gnt_d) begin
          owner_nx       = OWN_D;
          flushed_nx     = 1'b0;
          wr_nx          = bus.d_we_i;
          bus.ram_addr_o = bus.d_addr_i;
          if (bus.d_we_i) begin
            bus.ram_we_o    = bus.d_be_i;
            bus.ram_wdata_o = bus.d_wdata_i;
            state_nx        = ACK;
          end else begin
            bus.ram_re_o = 1'b1;
            cnt_nx       = LAT_CNT_W'(RD_LATENCY - 1);
            state_nx     = (RD_LATENCY == 1) ? ACK : RD_WAIT;
          end
        end else if (gnt_i) begin
          owner_nx       = OWN_I;
          flushed_nx     = 1'b0;
          wr_nx          = 1'b0;
          bus.ram_addr_o = bus.i_addr_i;
          bus.ram_re_o   = 1'b1;
          cnt_nx         = LAT_CNT_W'(RD_LATENCY - 1);
          state_nx       = (RD_LATENCY == 1) ? ACK : RD_WAIT;
        end else begin
          state_nx = IDLE;
        end
      end
      RD_WAIT: begin
        cnt_nx   = cnt - LAT_CNT_W'(1);
        state_nx = (cnt == LAT_CNT_W'(1)) ? ACK : RD_WAIT;
      end
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // a flush anywhere in a fetch transaction kills its ack
    if ((state != IDLE) && (owner == OWN_I) && bus.i_flush_i) begin
      flushed_nx = 1'b1;
    end else begin
      flushed_nx = flushed_nx;
    end
  end

  // state register; write acks are issued straight from the grant, read acks after ACK
  always_ff @(posedge clk_i) begin
    if (!n_rst) begin
      state   <= IDLE;
      owner   <= OWN_I;
      cnt     <= {LAT_CNT_W{1'b0}};
      flushed <= 1'b0;
      wr      <= 1'b0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      i_rdata <= {DATA_W{1'b0}};
      d_rdata <= {DATA_W{1'b0}};
    end else begin
      state   <= state_nx;
      owner   <= owner_nx;
      cnt     <= cnt_nx;
      flushed <= flushed_nx;
      wr      <= wr_nx;
      i_ack   <= i_done;
      d_ack   <= d_done || (gnt_d && bus.d_we_i);
      if (i_done) i_rdata <= bus.ram_rdata_i;
      if (d_done) d_rdata <= bus.ram_rdata_i;
    end
  end

  assign bus.i_ack_o   = i_ack;
  assign bus.d_ack_o   = d_ack;
  assign bus.i_rdata_o = i_rdata;
  assign bus.d_rdata_o = d_rdata;
  assign bus.busy_o    = n_rst && ((state != IDLE) ||
                                   ((bus.i_req_i || bus.d_req_i) && !gnt_i && !gnt_d));

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a latency-accurate BRAM model.
module tb_ram_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int L   = 3;
  localparam int MDS = 4;

  typedef struct {
    logic [31:0] addr;
    logic        re;
    logic [3:0]  we;
    int          cyc;
  } gnt_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [31:0] mem     [0:511];
  logic [31:0] ref_mem [0:511];
  logic [31:0] pipe    [0:L-1];
  logic [31:0] iq[$];
  logic [31:0] dq[$];
  logic [31:0] last_d_exp = 32'd0;
  gnt_t        glog[$];
  gnt_t        mon_g;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(L), .MAX_DATA_STREAK(MDS)
  ) dut (
    .clk_i (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  // BRAM model: read data valid L cycles after the strobe, byte-masked writes
  always @(posedge clk) begin
    pipe[0] <= mem[bus.ram_addr_o[10:2]];
    for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    for (int b = 0; b < 4; b++)
      if (bus.ram_we_o[b]) mem[bus.ram_addr_o[10:2]][8*b +: 8] <= bus.ram_wdata_o[8*b +: 8];
  end
  assign bus.ram_rdata_i = pipe[L-1];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // grant logger and ack scoreboard
  always @(negedge clk) begin
    if (bus.ram_re_o || (bus.ram_we_o != 4'd0)) begin
      mon_g.addr = bus.ram_addr_o;
      mon_g.re   = bus.ram_re_o;
      mon_g.we   = bus.ram_we_o;
      mon_g.cyc  = cyc;
      glog.push_back(mon_g);
    end
    if (bus.i_ack_o) begin
      if (iq.size() == 0) check_eq("i_ack_unexpected", {63'd0, bus.i_ack_o}, 64'd0);
      else check_eq("i_rdata", {32'd0, bus.i_rdata_o}, {32'd0, iq.pop_front()});
    end
    if (bus.d_ack_o) begin
      if (dq.size() == 0) check_eq("d_ack_unexpected", {63'd0, bus.d_ack_o}, 64'd0);
      else check_eq("d_rdata", {32'd0, bus.d_rdata_o}, {32'd0, dq.pop_front()});
    end
  end

  function automatic gnt_t last_grant(input logic [31:0] a);
    gnt_t r;
    r.addr = 32'd0; r.re = 1'b0; r.we = 4'd0; r.cyc = -1;
    foreach (glog[j]) if (glog[j].addr == a) r = glog[j];
    return r;
  endfunction

  function automatic int grant_cnt(input logic [31:0] a);
    int n = 0;
    foreach (glog[j]) if (glog[j].addr == a) n++;
    return n;
  endfunction

  // called and returns at posedge+1
  task automatic fetch_txn(input logic [31:0] a, output int lat, output int t0);
    bit got = 1'b0;
    bus.i_addr_i = a;
    bus.i_req_i  = 1'b1;
    t0  = cyc;
    lat = -1;
    iq.push_back(ref_mem[a[10:2]]);
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (bus.i_ack_o) begin got = 1'b1; lat = cyc - t0; end
    end
    check_eq("i_ack_timeout", {63'd0, got}, 64'd1);
    @(posedge clk); #1;
    bus.i_req_i = 1'b0;
  endtask

  task automatic data_txn(input logic we, input logic [3:0] be, input logic [31:0] a,
                          input logic [31:0] wd, output int lat, output int t0);
    bit got = 1'b0;
    bus.d_we_i    = we;
    bus.d_be_i    = be;
    bus.d_addr_i  = a;
    bus.d_wdata_i = wd;
    bus.d_req_i   = 1'b1;
    t0  = cyc;
    lat = -1;
    if (we) begin
      for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a[10:2]][8*b +: 8] = wd[8*b +: 8];
    end else begin
      last_d_exp = ref_mem[a[10:2]];
    end
    dq.push_back(last_d_exp);
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (bus.d_ack_o) begin got = 1'b1; lat = cyc - t0; end
    end
    check_eq("d_ack_timeout", {63'd0, got}, 64'd1);
    @(posedge clk); #1;
    bus.d_req_i = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_ctl"}, {55'd0, bus.ram_re_o, bus.ram_we_o, bus.busy_o, bus.i_ack_o, bus.d_ack_o},
             64'd0);
    check_eq({tag, "_addr"}, {bus.ram_addr_o, bus.ram_wdata_o}, 64'd0);
    check_eq({tag, "_rdata"}, {bus.i_rdata_o, bus.d_rdata_o}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, t0, lat2, t1, t;
    int ipos[$];
    int exp0, exp1;
    gnt_t g;

    for (int i = 0; i < 512; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[4]  = 32'h0000_0013;
    mem[32] = 32'hDEAD_BEEF;
    mem[16] = 32'h1122_3344;
    for (int i = 0; i < 512; i++) ref_mem[i] = mem[i];
    bus.i_req_i = 1'b0; bus.i_addr_i = 32'd0; bus.i_flush_i = 1'b0;
    bus.d_req_i = 1'b0; bus.d_we_i = 1'b0; bus.d_be_i = 4'd0;
    bus.d_addr_i = 32'd0; bus.d_wdata_i = 32'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1; n_rst = 1'b1;
    @(posedge clk); #1;

    // single fetch
    fetch_txn(32'h10, lat, t0);
    check_eq("fetch_lat", lat, L + 1);
    g = last_grant(32'h10);
    check_eq("fetch_re_cyc", g.cyc, t0);
    check_eq("fetch_re", {63'd0, g.re}, 64'd1);

    // simultaneous requests: data first, fetch the cycle after d_ack
    fork
      data_txn(1'b0, 4'd0, 32'h80, 32'd0, lat, t0);
      fetch_txn(32'h14, lat2, t1);
    join
    check_eq("sim_d_lat", lat, L + 1);
    check_eq("sim_i_lat", lat2, 2 * L + 3);
    check_eq("sim_i_gnt_cyc", last_grant(32'h14).cyc, t0 + lat + 1);

    // byte-masked write then read back
    data_txn(1'b1, 4'b0011, 32'h40, 32'h0000_ABCD, lat, t0);
    check_eq("wr_lat", lat, 1);
    g = last_grant(32'h40);
    check_eq("wr_we", {60'd0, g.we}, 64'h3);
    check_eq("wr_no_re", {63'd0, g.re}, 64'd0);
    check_eq("wr_one_strobe", grant_cnt(32'h40), 1);
    data_txn(1'b0, 4'd0, 32'h40, 32'd0, lat, t0);
    check_eq("rdback_lat", lat, L + 1);
    repeat (3) @(negedge clk);
    check_eq("d_rdata_hold", {32'd0, bus.d_rdata_o}, {32'd0, ref_mem[16]});
    @(posedge clk); #1;

    // flush during RD_WAIT: RAM side completes, no i_ack
    bus.i_addr_i = 32'h20; bus.i_req_i = 1'b1; t = cyc;
    @(posedge clk); #1; bus.i_flush_i = 1'b1; bus.i_req_i = 1'b0;
    @(posedge clk); #1; bus.i_flush_i = 1'b0;
    @(negedge clk); check_eq("flush_busy_wait", {63'd0, bus.busy_o}, 64'd1);
    @(negedge clk); check_eq("flush_busy_ack", {63'd0, bus.busy_o}, 64'd1);
    @(negedge clk); check_eq("flush_idle", {63'd0, bus.busy_o}, 64'd0);
    check_eq("flush_gnt_cyc", last_grant(32'h20).cyc, t);
    @(posedge clk); #1;
    // flush in IDLE blocks the fetch grant
    bus.i_addr_i = 32'h24; bus.i_req_i = 1'b1; bus.i_flush_i = 1'b1;
    @(negedge clk);
    check_eq("flush_idle_no_re", {63'd0, bus.ram_re_o}, 64'd0);
    check_eq("flush_idle_busy", {63'd0, bus.busy_o}, 64'd1);
    @(posedge clk); #1; bus.i_req_i = 1'b0; bus.i_flush_i = 1'b0;
    data_txn(1'b0, 4'd0, 32'h80, 32'd0, lat, t0);
    check_eq("post_flush_lat", lat, L + 1);

    // reset while a read is waiting on the RAM
    bus.d_addr_i = 32'h84; bus.d_we_i = 1'b0; bus.d_req_i = 1'b1;
    @(posedge clk); #1; n_rst = 1'b0; bus.d_req_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_outputs_zero("midrst");
    @(posedge clk); #1; n_rst = 1'b1; last_d_exp = 32'd0;
    repeat (6) @(posedge clk);
    @(negedge clk); check_eq("midrst_idle", {63'd0, bus.busy_o}, 64'd0);
    @(posedge clk); #1;
    data_txn(1'b0, 4'd0, 32'h80, 32'd0, lat, t0);
    check_eq("post_rst_lat", lat, L + 1);

    // both masters hammering: grant order
    glog.delete();
    fork
      begin
        int dl, dt;
        for (int k = 0; k < 10; k++) data_txn(1'b0, 4'd0, 32'h100 + 4 * k, 32'd0, dl, dt);
      end
      begin
        int fl, ft;
        for (int k = 0; k < 2; k++) fetch_txn(32'h30 + 4 * k, fl, ft);
      end
    join
    foreach (glog[j]) if (glog[j].addr < 32'h100) ipos.push_back(j);
`ifdef RAM_ARB_STARVE_GUARD_EN
    exp0 = MDS;
    exp1 = 2 * MDS + 1;
`else
    exp0 = 10;
    exp1 = 11;
`endif
    check_eq("grant_total", glog.size(), 12);
    check_eq("i_grant_count", ipos.size(), 2);
    if (ipos.size() >= 2) begin
      check_eq("i_grant_pos0", ipos[0], exp0);
      check_eq("i_grant_pos1", ipos[1], exp1);
    end

    repeat (4) @(posedge clk);
    check_eq("sb_empty", iq.size() + dq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
